// File: rtl/sub_diff_buffer_pkg.sv
// Shared constants, FIFO entry layout and occupancy encoding for the
// subtractor result buffer.
package sub_pkg;

   localparam int SUB_WIDTH = 16;
   localparam int SUB_CNT_W = 8;

   typedef struct packed {
      logic [SUB_WIDTH:1] mag;
      logic               neg;
      logic               zero;
   } sub_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

endpackage

// File: rtl/sub_diff_buffer_abs.sv
// Combinational magnitude/zero extraction from a difference and its borrow.
import sub_pkg::*;

module sub_abs_16bit (
   input  logic [SUB_WIDTH:1] D,
   input  logic               B_out,
   output logic [SUB_WIDTH:1] mag,
   output logic               zero
);

   // D == 0 with a borrow folds to mag 0 naturally through the two's complement.
   always_comb begin
      mag  = {SUB_WIDTH{1'b0}};
      zero = (D == {SUB_WIDTH{1'b0}});
      if (B_out) begin
         mag = (~D) + {{(SUB_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag = D;
      end
   end

endmodule

// File: rtl/sub_diff_buffer.sv
// Two-entry result FIFO for the 16-bit subtractor with a saturating count of
// negative results.
import sub_pkg::*;

module sub_diff_buffer #(
   parameter int WIDTH = SUB_WIDTH,
   parameter int CNT_W = SUB_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:1]   D,
   input  logic             B_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:1]   mag,
   output logic             neg,
   output logic             zero,
   output logic [CNT_W:1]   neg_cnt,
   input  logic             neg_clr
);

   localparam logic [CNT_W:1] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W:1] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   occ_t             state;
   occ_t             state_next;
   logic             head;
   logic             tail;
   sub_entry_t       mem [2];
   sub_entry_t       in_entry;
   logic [WIDTH:1]   in_mag;
   logic             in_zero;
   logic             push;
   logic             pop;
   logic             neg_push;

   sub_abs_16bit u_abs (
      .D     (D),
      .B_out (B_out),
      .mag   (in_mag),
      .zero  (in_zero)
   );

   assign in_ready = (state != OCC_FULL);
   assign out_valid = (state != OCC_EMPTY);
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign neg_push = push && B_out;

   assign in_entry = '{mag: in_mag, neg: B_out, zero: in_zero};

   assign mag  = mem[head].mag;
   assign neg  = mem[head].neg;
   assign zero = mem[head].zero;

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= OCC_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Occupancy next-state; simultaneous push/pop can only occur in ONE.
   always_comb begin
      state_next = state;
      case (state)
         OCC_EMPTY: begin
            if (push) state_next = OCC_ONE;
            else      state_next = OCC_EMPTY;
         end
         OCC_ONE: begin
            if (push && !pop)      state_next = OCC_FULL;
            else if (!push && pop) state_next = OCC_EMPTY;
            else                   state_next = OCC_ONE;
         end
         OCC_FULL: begin
            if (pop) state_next = OCC_ONE;
            else     state_next = OCC_FULL;
         end
         default: state_next = OCC_EMPTY;
      endcase
   end

   // Storage and pointers; storage is cleared so outputs read 0 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head   <= 1'b0;
         tail   <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[tail] <= in_entry;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
      end
   end

   // Saturating negative-result counter; a clear still counts a same-cycle negative push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         neg_cnt <= {CNT_W{1'b0}};
      end else if (neg_clr) begin
         neg_cnt <= neg_push ? CNT_ONE : {CNT_W{1'b0}};
      end else if (neg_push && (neg_cnt != CNT_MAX)) begin
         neg_cnt <= neg_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_sub_diff_buffer.sv
// Scoreboard bench for sub_diff_buffer: driver queues expected entries on
// acceptance, a negedge monitor pops and compares on every output handshake.
import sub_pkg::*;

module tb_sub_diff_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [16:1] D;
   logic        B_out;
   logic        out_valid;
   logic        out_ready;
   logic [16:1] mag;
   logic        neg;
   logic        zero;
   logic [8:1]  neg_cnt;
   logic        neg_clr;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   sub_entry_t exp_q [$];

   always #5 clk = ~clk;

   sub_diff_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (D),
      .B_out     (B_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag       (mag),
      .neg       (neg),
      .zero      (zero),
      .neg_cnt   (neg_cnt),
      .neg_clr   (neg_clr)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: a pop occurs at the next rising edge when out_valid && out_ready here.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         sub_entry_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected got mag %0h with empty scoreboard", mag);
         end else begin
            e = exp_q.pop_front();
            if (mag !== e.mag || neg !== e.neg || zero !== e.zero) begin
               errors++;
               $display("FAIL out_entry got mag %0h neg %0b zero %0b expected mag %0h neg %0b zero %0b",
                        mag, neg, zero, e.mag, e.neg, e.zero);
            end
         end
         pops++;
      end
   end

   // Present a pair until accepted; the expected entry is queued on acceptance.
   task automatic send(input logic [16:1] d, input logic b, input logic [16:1] exp_mag);
      bit done = 1'b0;
      in_valid = 1'b1;
      D        = d;
      B_out    = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back('{mag: exp_mag, neg: b, zero: (d == 16'h0000)});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         errors++;
         $display("FAIL send_timeout got in_ready 0 expected 1 for D %0h", d);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      int p0;
      logic [16:1] d;
      logic        b;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      D         = 16'h0000;
      B_out     = 1'b0;
      out_ready = 1'b0;
      neg_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_neg_cnt", {24'd0, neg_cnt}, 32'd0);
      check("reset_mag", {16'd0, mag}, 32'd0);

      // Negative result with 1-cycle latency.
      out_ready = 1'b1;
      send(16'hFFFF, 1'b1, 16'h0001);
      check("neg_latency_out_valid", {31'd0, out_valid}, 32'd1);
      check("neg_cnt_after_neg", {24'd0, neg_cnt}, 32'd1);
      check("neg_flag", {31'd0, neg}, 32'd1);
      wait_drain();

      // Zero result leaves the counter alone.
      send(16'h0000, 1'b0, 16'h0000);
      check("zero_flag", {31'd0, zero}, 32'd1);
      wait_drain();
      check("neg_cnt_after_zero", {24'd0, neg_cnt}, 32'd1);

      // Odd case: zero difference with a borrow.
      send(16'h0000, 1'b1, 16'h0000);
      wait_drain();

      // Backpressure then ordered drain.
      out_ready = 1'b0;
      p0 = pops;
      send(16'h0005, 1'b0, 16'h0005);
      send(16'hFFF6, 1'b1, 16'h000A);
      in_valid = 1'b1;
      D        = 16'h0007;
      B_out    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      send(16'h0007, 1'b0, 16'h0007);
      wait_drain();
      check("backpressure_pops", pops - p0, 32'd3);

      // Streaming with simultaneous push and pop.
      p0 = pops;
      for (int i = 1; i <= 20; i++) begin
         d = 16'(i) * 16'h0101;
         b = i[0];
         send(d, b, b ? (16'h0000 - d) : d);
         if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            check("stream_ready_valid", {30'd0, in_ready, out_valid}, 32'd3);
         end
      end
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      check("stream_out_valid", {31'd0, out_valid}, 32'd1);
      wait_drain();
      check("stream_pops", pops - p0, 32'd20);

      // Counter saturation and clear.
      for (int i = 0; i < 300; i++) send(16'hFFFF, 1'b1, 16'h0001);
      check("neg_cnt_saturated", {24'd0, neg_cnt}, 32'd255);
      neg_clr = 1'b1;
      send(16'hFFFE, 1'b1, 16'h0002);
      neg_clr = 1'b0;
      check("neg_cnt_clr_with_push", {24'd0, neg_cnt}, 32'd1);
      neg_clr = 1'b1;
      @(posedge clk);
      #1;
      neg_clr = 1'b0;
      check("neg_cnt_clr_alone", {24'd0, neg_cnt}, 32'd0);
      wait_drain();

      // Reset while full.
      out_ready = 1'b0;
      send(16'h0011, 1'b0, 16'h0011);
      send(16'hFFF0, 1'b1, 16'h0010);
      check("prereset_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
      check("midreset_neg_cnt", {24'd0, neg_cnt}, 32'd0);
      check("midreset_mag", {16'd0, mag}, 32'd0);
      p0 = pops;
      out_ready = 1'b1;
      send(16'hFFFD, 1'b1, 16'h0003);
      wait_drain();
      check("postreset_pops", pops - p0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
